set_assoc_cache: RTL



---
 rtl/set_assoc_cache.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, write-back, write-allocate data cache
// with true-LRU replacement, one DATA_W word per line.
// Ports:
//   clk, rst (sync, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  -> request, held until cpu_done
//   cpu_rdata/cpu_done/hit             <- registered completion (hit qualified by done)
//   mem_req/mem_we/mem_addr/mem_wdata  -> registered miss path, held until mem_ack
//   mem_rdata/mem_ack                  <- refill data / completion
// Optional macro CACHE_STATS_EN adds saturating hit_cnt / miss_cnt outputs.

// Per-way tag compare and LRU age update.
module set_assoc_cache_way #(
  parameter int TW = 26,
  parameter int AW = 1
) (
  input  logic          valid,
  input  logic [TW-1:0] tag,
  input  logic [TW-1:0] tg,
  input  logic [AW-1:0] age,
  input  logic [AW-1:0] acc_age,
  input  logic          sel,
  output logic          match,
  output logic [AW-1:0] age_nxt
);
  assign match   = valid && (tag == tg);
  // accessed way becomes youngest; ways younger than it age by one
  assign age_nxt = sel ? '0 : ((age < acc_age) ? age + AW'(1) : age);
endmodule

module set_assoc_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - 2 - IW;
  localparam int AW = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state, state_d;

  logic [ADDR_W-3:0] ad_q;
  logic              we_q;
  logic [DATA_W-1:0] wd_q;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tg;

  logic [SETS-1:0][WAYS-1:0]             valid_q, dirty_q;
  logic [SETS-1:0][WAYS-1:0][TW-1:0]     tag_q;
  logic [SETS-1:0][WAYS-1:0][DATA_W-1:0] data_q;
  logic [SETS-1:0][WAYS-1:0][AW-1:0]     age_q;

  logic [WAYS-1:0]         match, sel;
  logic [WAYS-1:0][AW-1:0] age_nxt;
  logic                    any_hit, touch, found;
  logic [AW-1:0]           hw, vic, way_q, tw;

  logic              done_d, hit_d, mreq_d, mwe_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [DATA_W-1:0] mwdata_d, rdata_d;

  // byte-offset bits are don't-care
  logic unused_bits;
  assign unused_bits = ^cpu_addr[1:0];

  assign idx = ad_q[IW-1:0];
  assign tg  = ad_q[ADDR_W-3 -: TW];

  always_comb begin
    for (int w = 0; w < WAYS; w++) sel[w] = touch && (tw == AW'(w));
  end

  set_assoc_cache_way #(.TW(TW), .AW(AW)) u_way [WAYS-1:0] (
    .valid   (valid_q[idx]),
    .tag     (tag_q[idx]),
    .tg      (tg),
    .age     (age_q[idx]),
    .acc_age (age_q[idx][tw]),
    .sel     (sel),
    .match   (match),
    .age_nxt (age_nxt)
  );

  // hit way, and victim: lowest invalid way, else the oldest (age WAYS-1)
  always_comb begin
    any_hit = 1'b0;
    hw      = '0;
    vic     = '0;
    found   = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) begin any_hit = 1'b1; hw = AW'(w); end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[idx][w]) begin found = 1'b1; vic = AW'(w); end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == AW'(WAYS-1)) vic = AW'(w);
      end
    end
  end

  always_comb begin
    state_d  = state;
    done_d   = 1'b0;
    hit_d    = 1'b0;
    rdata_d  = cpu_rdata;
    mreq_d   = mem_req;
    mwe_d    = mem_we;
    maddr_d  = mem_addr;
    mwdata_d = mem_wdata;
    touch    = 1'b0;
    tw       = way_q;
    case (state)
      IDLE: if (cpu_req) state_d = LOOKUP;
      LOOKUP: begin
        if (any_hit) begin
          done_d  = 1'b1;
          hit_d   = 1'b1;
          rdata_d = we_q ? wd_q : data_q[idx][hw];
          touch   = 1'b1;
          tw      = hw;
          state_d = IDLE;
        end else if (valid_q[idx][vic] && dirty_q[idx][vic]) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = {tag_q[idx][vic], idx, 2'b00};
          mwdata_d = data_q[idx][vic];
          state_d  = WRITEBACK;
        end else if (!we_q) begin
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = {tg, idx, 2'b00};
          state_d = REFILL;
        end else begin
          state_d = RESPOND;
        end
      end
      WRITEBACK: if (mem_ack) begin
        mwe_d = 1'b0;
        if (!we_q) begin
          // request stays up; it turns into the refill read
          maddr_d = {tg, idx, 2'b00};
          state_d = REFILL;
        end else begin
          mreq_d  = 1'b0;
          state_d = RESPOND;
        end
      end
      REFILL: if (mem_ack) begin
        mreq_d  = 1'b0;
        state_d = RESPOND;
      end
      RESPOND: begin
        done_d  = 1'b1;
        rdata_d = we_q ? wd_q : data_q[idx][way_q];
        touch   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      cpu_done  <= 1'b0;
      hit       <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cpu_done  <= done_d;
      hit       <= hit_d;
      cpu_rdata <= rdata_d;
      mem_req   <= mreq_d;
      mem_we    <= mwe_d;
      mem_addr  <= maddr_d;
      mem_wdata <= mwdata_d;
      if (state == IDLE && cpu_req) begin
        ad_q <= cpu_addr[ADDR_W-1:2];
        we_q <= cpu_we;
        wd_q <= cpu_wdata;
      end
      if (state == LOOKUP) begin
        way_q <= vic;
        if (any_hit && we_q) begin
          data_q[idx][hw]  <= wd_q;
          dirty_q[idx][hw] <= 1'b1;
        end
      end
      if (state == REFILL && mem_ack) begin
        data_q[idx][way_q]  <= mem_rdata;
        tag_q[idx][way_q]   <= tg;
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= 1'b0;
      end
      if (state == RESPOND && we_q) begin
        data_q[idx][way_q]  <= wd_q;
        tag_q[idx][way_q]   <= tg;
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= 1'b1;
      end
      if (touch) age_q[idx] <= age_nxt;
    end
  end

`ifdef CACHE_STATS_EN
  // counters step on the same edge that raises cpu_done
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (done_d) begin
      if (hit_d && hit_cnt != '1)   hit_cnt  <= hit_cnt + 32'd1;
      if (!hit_d && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  // statistics counters not built
`endif

endmodule
